// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: merges stall requests, sequences
// exception/ERET flushes with PC redirect, and keeps debug performance counters.
module pipeline_ctrl #(
    parameter int unsigned FLUSH_HOLD    = 1,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_stall_req,
    input  logic                 id_stall_req,
    input  logic                 ex_stall_req,
    input  logic                 mem_stall_req,
    input  logic                 exc_valid,
    input  logic [31:0]          exc_handler,
    input  logic                 eret_valid,
    input  logic [31:0]          epc,
    input  logic                 timeout_clr,
    output logic [4:0]           stall,
    output logic                 flush,
    output logic                 redirect_en,
    output logic [31:0]          redirect_pc,
    output logic                 busy_flush,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [15:0]          flush_cnt,
    output logic                 stall_timeout
);

    localparam int unsigned HOLD_W = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD + 1) : 1;
    localparam int unsigned RUN_W  = $clog2(STALL_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FLUSH_HOLD);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(STALL_TIMEOUT);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_next;
    logic [RUN_W-1:0]   run_cnt, run_next;

    logic [4:0]         stall_c;
    logic               flush_c;
    logic               redirect_en_c;
    logic [31:0]        redirect_pc_c;
    logic               event_accept;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next    = state;
        hold_next     = hold_cnt;
        stall_c       = 5'b00000;
        flush_c       = 1'b0;
        redirect_en_c = 1'b0;
        redirect_pc_c = 32'h0;
        event_accept  = 1'b0;

        unique case (state)
            RUN: begin
                if (exc_valid || eret_valid) begin
                    flush_c       = 1'b1;
                    redirect_en_c = 1'b1;
                    redirect_pc_c = exc_valid ? exc_handler : epc;
                    event_accept  = 1'b1;
                    if (FLUSH_HOLD > 0) begin
                        state_next = FLUSH;
                        hold_next  = HOLD_INIT;
                    end
                end else if (mem_stall_req) begin
                    stall_c = 5'b11111;
                end else if (ex_stall_req) begin
                    stall_c = 5'b01111;
                end else if (id_stall_req) begin
                    stall_c = 5'b00111;
                end else if (if_stall_req) begin
                    stall_c = 5'b00011;
                end
            end

            FLUSH: begin
                // Requests and events arriving here are dropped, not queued.
                flush_c   = 1'b1;
                hold_next = hold_cnt - HOLD_W'(1);
                if (hold_cnt <= HOLD_W'(1)) begin
                    state_next = RUN;
                end
            end

            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Consecutive-stall run length; any stall-free cycle (flush included) restarts it.
    always_comb begin
        run_next = run_cnt;
        if (timeout_clr || (stall_c == 5'b00000)) begin
            run_next = '0;
        end else if (run_cnt != RUN_MAX) begin
            run_next = run_cnt + RUN_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt       <= '0;
            stall_timeout <= 1'b0;
        end else begin
            run_cnt <= run_next;
            if (timeout_clr) begin
                stall_timeout <= 1'b0;
            end else if (run_next == RUN_MAX) begin
                stall_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((stall_c != 5'b00000) && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (event_accept && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

    // Mealy outputs are forced low while reset is asserted, even with requests pending.
    assign stall       = rst ? 5'b00000 : stall_c;
    assign flush       = rst ? 1'b0     : flush_c;
    assign redirect_en = rst ? 1'b0     : redirect_en_c;
    assign redirect_pc = rst ? 32'h0    : redirect_pc_c;
    assign busy_flush  = (state == FLUSH);

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into one hold vector; the load-use stall request from decode enters here.
- Sequences exception and ERET flushes through a small FSM and drives PC redirect.
- Keeps saturating stall/flush performance counters and a sticky stall-timeout flag for debug.

Parameters:
- FLUSH_HOLD, 1, extra cycles flush stays high after the event cycle (0 allowed).
- STALL_TIMEOUT, 1024, consecutive stalled cycles that set stall_timeout (must be ≥1).
- CNT_WIDTH, 32, width of stall_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- if_stall_req  in  1  instruction bus not ready.
- id_stall_req  in  1  decode stall (load-use).
- ex_stall_req  in  1  EX multi-cycle busy (mul/div).
- mem_stall_req  in  1  data bus not ready.
- exc_valid  in  1  exception committed in MEM.
- exc_handler  in  32  exception vector address.
- eret_valid  in  1  ERET committed in MEM.
- epc  in  32  return address.
- timeout_clr  in  1  clears stall_timeout.
- stall  out  5  hold enables [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB.
- flush  out  1  clear all pipeline registers.
- redirect_en  out  1  PC load pulse.
- redirect_pc  out  32  PC load value.
- busy_flush  out  1  FSM in FLUSH state.
- stall_cnt  out  CNT_WIDTH  stalled-cycle counter.
- flush_cnt  out  16  flush-event counter.
- stall_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (async, any state): FSM=RUN, hold counter=0, run counter=0, stall_cnt=0, flush_cnt=0, stall_timeout=0.
- Reset outputs: stall=0, flush=0, redirect_en=0, redirect_pc=0, busy_flush=0.
- States: RUN, FLUSH.
- RUN, no event: stall is combinational, highest-priority request wins:
  - mem_stall_req → 5'b11111
  - else ex_stall_req → 5'b01111
  - else id_stall_req → 5'b00111
  - else if_stall_req → 5'b00011
  - else 5'b00000
- RUN, event (exc_valid or eret_valid), same cycle, Mealy:
  - flush=1, redirect_en=1, stall=0; all stall requests ignored.
  - redirect_pc = exc_handler if exc_valid, else epc; exc_valid wins when both are high.
  - flush_cnt += 1.
  - If FLUSH_HOLD>0: next state FLUSH, hold counter=FLUSH_HOLD. Else stay in RUN.
- FLUSH:
  - Outputs: flush=1, busy_flush=1, redirect_en=0, stall=0.
  - exc_valid, eret_valid and all stall requests ignored (not queued).
  - Hold counter decrements each cycle; at 1 → RUN next cycle.
  - Total flush length = 1 + FLUSH_HOLD cycles.
- redirect_en is high exactly 1 cycle per accepted event. redirect_pc is 0 whenever redirect_en=0.
- stall_cnt: +1 each cycle stall≠0; saturates at all-ones; no wrap.
- flush_cnt: +1 per accepted event, never on hold cycles; saturates at 16'hFFFF.
- Run counter:
  - Counts consecutive cycles with stall≠0; cleared on any cycle with stall=0, including flush cycles.
  - Saturates at STALL_TIMEOUT.
  - stall_timeout sets on the edge where the count reaches STALL_TIMEOUT, then stays set.
- timeout_clr:
  - Clears stall_timeout and the run counter next edge.
  - Wins over a simultaneous set.
- All state is registered on posedge clk; only stall, flush, redirect_en and redirect_pc are combinational from inputs in RUN.

Test Plan:
- Priority merge: id_stall_req=1 and mem_stall_req=1 in RUN → stall=5'b11111. Then drop mem_stall_req → stall=5'b00111 that cycle. stall_cnt +2.
- Exception with stall: ex_stall_req=1, exc_valid=1, exc_handler=32'hBFC00380, FLUSH_HOLD=1 → cycle N: stall=0, flush=1, redirect_en=1, redirect_pc=32'hBFC00380. Cycle N+1: flush=1, busy_flush=1, redirect_en=0. Cycle N+2: RUN, stall=5'b01111 if request still held. flush_cnt=1.
- Simultaneous exc/eret: exc_valid=1, eret_valid=1, epc=32'h80001000, exc_handler=32'hBFC00380 → redirect_pc=32'hBFC00380.
- Event ignored during FLUSH: eret_valid pulsed in cycle N+1 → no redirect_en, flush_cnt unchanged.
- Timeout: STALL_TIMEOUT=4, hold ex_stall_req 4 cycles → stall_timeout=1 after 4th edge. Drop request → flag stays 1. timeout_clr=1 → 0 next edge.
- Async reset mid-FLUSH: assert rst between edges → all outputs 0 immediately. After release: RUN, counters 0.
